// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions and fetch FSM encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;

  localparam logic [3:0] AM_IMM = 4'd8;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/sisc_pc_next.sv
// Next-PC selection: sequential increment, PC-relative branch or absolute branch.
// All arithmetic wraps modulo 2^AW.
module sisc_pc_next #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] offset,
  input  logic          pc_sel,
  input  logic          br_sel,
  output logic [AW-1:0] next_pc
);

  // Pick the candidate PC from the controller's select lines.
  always_comb begin
    next_pc = pc + AW'(1);
    if (pc_sel) begin
      next_pc = br_sel ? offset : (pc + offset);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC fetch unit: owns PC and IR, executes controller PC/IR commands and fetches
// instructions over a req/ack bus.
// Optional macro FETCH_TIMEOUT_EN: abandon a fetch after TIMEOUT cycles without ack,
// load NOOP into IR and raise a sticky fetch_err.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  fetch_unit_if.master  bus,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          fetch_err
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  sisc_pc_next #(.AW(AW)) u_pc_next (
    .pc      (pc_q),
    .offset  (ir_q[AW-1:0]),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .next_pc (next_pc)
  );

  // State and datapath registers, cleared asynchronously by rst_f.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next state and next register values; pc_rst aborts everything and wins over other commands.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (pc_rst) begin
      state_d = FS_IDLE;
      pc_d    = '0;
      ir_d    = '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      if (pc_write) begin
        pc_d = next_pc;
      end
      unique case (state_q)
        FS_IDLE: begin
          if (ir_load) begin
            addr_d  = pc_q;
            state_d = FS_WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        FS_WAIT: begin
          if (bus.imem_ack) begin
            ir_d    = bus.imem_rdata;
            state_d = FS_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            ir_d    = '0;
            err_d   = 1'b1;
            state_d = FS_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        FS_DONE: begin
          state_d = FS_IDLE;
        end
        default: begin
          state_d = FS_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    bus.imem_req = (state_q == FS_WAIT);
    fetch_busy   = (state_q != FS_IDLE);
    fetch_done   = (state_q == FS_DONE);
  end

  assign bus.imem_addr = addr_q;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign opcode        = ir_q[OPC_MSB:OPC_LSB];
  assign mm            = ir_q[MM_MSB:MM_LSB];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch responder that sits on the far side of the SISC controller's control interface.
- Owns the program counter (PC) and the instruction register (IR).
- Executes the controller's pc_rst / pc_write / pc_sel / br_sel / ir_load commands.
- Fetches instructions from instruction memory over a req/ack handshake and returns the opcode and mm fields to the controller.

Parameters:
- AW, 16, PC / instruction-memory address width.
- DW, 32, instruction width. Field layout: opcode = [31:28], mm = [27:24], address/offset = [AW-1:0].
- TIMEOUT, 15, maximum cycles waited for imem_ack (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_f  in  1  reset, asynchronous, active-low.
- pc_rst  in  1  synchronous PC clear, active-high, from the controller.
- pc_write  in  1  PC update enable.
- pc_sel  in  1  0: PC+1; 1: branch target.
- br_sel  in  1  0: relative target (PC + IR[AW-1:0]); 1: absolute target (IR[AW-1:0]).
- ir_load  in  1  fetch request pulse.
- imem_rdata  in  DW  instruction read data.
- imem_ack  in  1  read data valid this cycle.
- imem_req  out  1  read request, held until ack.
- imem_addr  out  AW  read address, stable while imem_req=1.
- pc  out  AW  current PC.
- ir  out  DW  instruction register.
- opcode  out  4  ir[31:28].
- mm  out  4  ir[27:24].
- fetch_busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse: IR updated.
- fetch_err  out  1  sticky fetch-timeout flag (optional feature only).

Behaviour:
- Reset (rst_f=0, async): pc=0, ir=0 (opcode NOOP), imem_req=0, imem_addr=0, fetch_busy=0, fetch_done=0, fetch_err=0, state IDLE.
- Next PC (registered on a clock edge when pc_write=1):
  - pc_sel=0: pc+1.
  - pc_sel=1, br_sel=0: pc + ir[AW-1:0].
  - pc_sel=1, br_sel=1: ir[AW-1:0].
  - All sums are unsigned modulo 2^AW; 0xFFFF+1 wraps to 0.
- pc_rst=1 (sync):
  - pc<=0, ir<=0, imem_req<=0, state<=IDLE.
  - Aborts any fetch in flight; no fetch_done is generated.
  - fetch_err cleared.
  - Overrides pc_write and ir_load in the same cycle.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: ir_load=1 -> capture imem_addr<=pc (value before any same-cycle pc_write), imem_req<=1, fetch_busy<=1, go WAIT.
  - WAIT: imem_ack=1 -> ir<=imem_rdata, imem_req<=0, go DONE. Otherwise hold; imem_addr stays constant.
  - DONE: fetch_done=1, fetch_busy<=0, go IDLE.
- Latency: ir_load in cycle 0, ack in cycle 1 -> new ir and fetch_done visible in cycle 2. Each additional cycle of ack delay adds one cycle.
- Boundary conditions:
  - ir_load in WAIT or DONE: ignored, not queued.
  - imem_ack outside WAIT: ignored.
  - pc_write during WAIT: PC updates normally; the in-flight address is unaffected.
  - pc_write together with ir_load in IDLE: fetch uses the old PC; PC advances on the same edge.
  - opcode and mm are always combinational slices of ir.
  - Async reset mid-fetch: all state returns to reset values immediately.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - After TIMEOUT cycles without ack: imem_req<=0, ir<=0 (NOOP), fetch_err<=1 (sticky until pc_rst or rst_f), go DONE (fetch_done still pulses).
  - A late ack is ignored.
- Undefined: WAIT holds indefinitely; fetch_err is tied 0; no counter logic.

Decomposition:
- Package sisc_pkg:
  - Opcode constants: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU_OP=8, HLT=15.
  - Field positions: OPC_MSB=31, OPC_LSB=28, MM_MSB=27, MM_LSB=24.
  - am_imm=8.
  - Fetch state encoding.
- Sub-module sisc_pc_next: combinational next-PC selection (pc, ir offset, pc_sel, br_sel -> next_pc); instantiated once.

Test Plan:
- Reset then ir_load, ack one cycle later with rdata=0x8100_0003 -> cycle 2: ir=0x81000003, opcode=8, mm=1, fetch_done=1, imem_addr=0.
- pc=0x0010, ir[15:0]=0x0005, pc_write=1, pc_sel=1, br_sel=0 -> pc=0x0015; same with br_sel=1 -> pc=0x0005.
- pc=0xFFFF, pc_write=1, pc_sel=0 -> pc=0x0000 (wrap).
- ir_load with ack delayed 4 cycles, pc_write pulsed in WAIT -> imem_addr constant, fetch_busy high for 5 cycles, one fetch_done; second ir_load issued in WAIT is ignored.
- pc_rst in WAIT, then ack -> ir=0, pc=0, no fetch_done; async rst_f low mid-fetch -> imem_req=0 immediately.
- With FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> after 15 WAIT cycles: ir=0, fetch_err=1, fetch_done pulses; pc_rst clears fetch_err.
